// File: rtl/ram_bist_ctrl.sv
`timescale 1ns/1ps
// RAM write/read-back self-test controller with an inferred single-port synchronous RAM.
// Writes an address-derived pattern over the full depth, reads it back one word per
// cycle, and reports pass/fail, a saturating mismatch count and the first failing address.
module ram_bist_ctrl #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned INJ_ADDR = 3,
    parameter int unsigned CONT     = 0
) (
    input  logic              clk_50M,
    input  logic              RST_N,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              inj_en,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] wrdata,
    output logic [DATA_W-1:0] rddata,
    output logic              wren,
    output logic              rden
);

    localparam int unsigned       DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
    logic [ADDR_W-1:0]   first_err_q, first_err_d;
    logic [ADDR_W-1:0]   address_q, address_d;
    logic [DATA_W-1:0]   wrdata_q, wrdata_d;
    logic                wren_q, wren_d;
    logic                rden_q, rden_d;
    logic [1:0]          mode_q, mode_d;
    logic                inj_q, inj_d;
    logic                rd_vld_q, rd_vld_d;
    logic [ADDR_W-1:0]   cmp_addr_q, cmp_addr_d;
    logic [DATA_W-1:0]   rddata_q;
    logic                start_run_c;
    logic [1:0]          run_mode_c;
    logic                run_inj_c;

    logic [DATA_W-1:0]   mem [DEPTH];

    // Reference pattern for a given mode and address.
    function automatic logic [DATA_W-1:0] pat_f(input logic [1:0] m, input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] a_ext;
        logic [DATA_W-1:0] cb;
        int unsigned       sh;
        a_ext = DATA_W'(a);
        cb    = DATA_W'({DATA_W{2'b01}});
        sh    = 32'(a) % DATA_W;
        case (m)
            2'd0:    pat_f = a_ext;
            2'd1:    pat_f = ~a_ext;
            2'd2:    pat_f = DATA_W'(1) << sh;
            default: pat_f = a[0] ? ~cb : cb;
        endcase
    endfunction

    // Write data: pattern with bit 0 flipped at the injection address when enabled.
    function automatic logic [DATA_W-1:0] wdat_f(input logic [1:0] m, input logic inj,
                                                 input logic [ADDR_W-1:0] a);
        wdat_f = pat_f(m, a) ^ DATA_W'(inj && (a == ADDR_W'(INJ_ADDR)));
    endfunction

    // Next-state, sequencing and read-back compare.
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        address_d   = address_q;
        wrdata_d    = wrdata_q;
        wren_d      = wren_q;
        rden_d      = rden_q;
        mode_d      = mode_q;
        inj_d       = inj_q;
        rd_vld_d    = rden_q;
        cmp_addr_d  = address_q;
        start_run_c = 1'b0;
        run_mode_c  = mode_q;
        run_inj_c   = inj_q;

        if (rd_vld_q && (rddata_q != pat_f(mode_q, cmp_addr_q))) begin
            if (err_cnt_q == '0) begin
                first_err_d = cmp_addr_q;
            end
            if (err_cnt_q != CNT_MAX) begin
                err_cnt_d = err_cnt_q + CNT_W'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                start_run_c = start;
            end
            S_WRITE: begin
                if (address_q == LAST_ADDR) begin
                    state_d   = S_READ;
                    wren_d    = 1'b0;
                    rden_d    = 1'b1;
                    address_d = '0;
                    wrdata_d  = '0;
                end else begin
                    address_d = address_q + ADDR_W'(1);
                    wrdata_d  = wdat_f(mode_q, inj_q, address_q + ADDR_W'(1));
                end
            end
            S_READ: begin
                if (address_q == LAST_ADDR) begin
                    state_d   = S_DRAIN;
                    rden_d    = 1'b0;
                    address_d = '0;
                end else begin
                    address_d = address_q + ADDR_W'(1);
                end
            end
            S_DRAIN: begin
                state_d = S_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                pass_d  = (err_cnt_d == '0);
            end
            S_DONE: begin
                start_run_c = start || (CONT != 0);
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (start_run_c) begin
            run_mode_c  = start ? mode : mode_q;
            run_inj_c   = start ? inj_en : inj_q;
            state_d     = S_WRITE;
            busy_d      = 1'b1;
            done_d      = 1'b0;
            pass_d      = 1'b0;
            err_cnt_d   = '0;
            first_err_d = '0;
            mode_d      = run_mode_c;
            inj_d       = run_inj_c;
            address_d   = '0;
            wren_d      = 1'b1;
            rden_d      = 1'b0;
            wrdata_d    = wdat_f(run_mode_c, run_inj_c, '0);
        end
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk_50M or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
            address_q   <= '0;
            wrdata_q    <= '0;
            wren_q      <= 1'b0;
            rden_q      <= 1'b0;
            mode_q      <= '0;
            inj_q       <= 1'b0;
            rd_vld_q    <= 1'b0;
            cmp_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
            address_q   <= address_d;
            wrdata_q    <= wrdata_d;
            wren_q      <= wren_d;
            rden_q      <= rden_d;
            mode_q      <= mode_d;
            inj_q       <= inj_d;
            rd_vld_q    <= rd_vld_d;
            cmp_addr_q  <= cmp_addr_d;
        end
    end

    // RAM array write port; contents survive reset.
    always_ff @(posedge clk_50M) begin
        if (wren_q) begin
            mem[address_q] <= wrdata_q;
        end
    end

    // RAM read register; q valid the cycle after rden.
    always_ff @(posedge clk_50M or negedge RST_N) begin
        if (!RST_N) begin
            rddata_q <= '0;
        end else if (rden_q) begin
            rddata_q <= mem[address_q];
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_cnt        = err_cnt_q;
    assign first_err_addr = first_err_q;
    assign address        = address_q;
    assign wrdata         = wrdata_q;
    assign rddata         = rddata_q;
    assign wren           = wren_q;
    assign rden           = rden_q;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
`timescale 1ns/1ps
// Bench for ram_bist_ctrl: cycle-exact scan of each run against a pattern/memory model.
module tb_ram_bist_ctrl;

    localparam int D = 32;

    logic        clk_50M = 1'b0;
    logic        RST_N   = 1'b0;

    logic        start   = 1'b0;
    logic [1:0]  mode    = 2'd0;
    logic        inj_en  = 1'b0;
    logic        busy, done, pass, wren, rden;
    logic [15:0] err_cnt;
    logic [4:0]  first_err_addr, address;
    logic [7:0]  wrdata, rddata;

    logic        s_start = 1'b0;
    logic [1:0]  s_mode  = 2'd0;
    logic        s_inj   = 1'b0;
    logic        s_busy, s_done, s_pass, s_wren, s_rden;
    logic [1:0]  s_err_cnt;
    logic [4:0]  s_first_err_addr, s_address;
    logic [7:0]  s_wrdata, s_rddata;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  wr_seen [D];
    logic [7:0]  rd_seen [D];

    wire [46:0] all_out   = {busy, done, pass, err_cnt, first_err_addr, address, wrdata, rddata, wren, rden};
    wire [32:0] s_all_out = {s_busy, s_done, s_pass, s_err_cnt, s_first_err_addr, s_address,
                             s_wrdata, s_rddata, s_wren, s_rden};
    wire [8:0]  ctrl      = {busy, done, wren, rden, address};

    ram_bist_ctrl u_dut (
        .clk_50M(clk_50M), .RST_N(RST_N), .start(start), .mode(mode), .inj_en(inj_en),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .first_err_addr(first_err_addr),
        .address(address), .wrdata(wrdata), .rddata(rddata), .wren(wren), .rden(rden)
    );

    ram_bist_ctrl #(.CNT_W(2), .CONT(1)) u_sat (
        .clk_50M(clk_50M), .RST_N(RST_N), .start(s_start), .mode(s_mode), .inj_en(s_inj),
        .busy(s_busy), .done(s_done), .pass(s_pass), .err_cnt(s_err_cnt),
        .first_err_addr(s_first_err_addr), .address(s_address), .wrdata(s_wrdata),
        .rddata(s_rddata), .wren(s_wren), .rden(s_rden)
    );

    always #10 clk_50M = ~clk_50M;

    // Intended pattern straight from the mode definitions.
    function automatic logic [7:0] ref_pat(input int m, input int a);
        case (m)
            0:       return 8'(a % 256);
            1:       return 8'(255 - (a % 256));
            2:       return 8'(1 << (a % 8));
            default: return ((a % 2) == 0) ? 8'h55 : 8'hAA;
        endcase
    endfunction

    function automatic logic [7:0] ref_wr(input int m, input bit inj, input int a);
        return ref_pat(m, a) ^ ((inj && a == 3) ? 8'h01 : 8'h00);
    endfunction

    // One full run; noise=1 toggles start/mode/inj_en randomly while busy.
    task automatic do_run(input int m, input bit inj, input bit noise);
        logic [7:0] mem_m [D];
        logic [8:0] exp_ctrl;
        int         exp_err, exp_first;
        @(negedge clk_50M);
        mode = 2'(m); inj_en = inj; start = 1'b1;
        for (int c = 1; c <= 2*D+2; c++) begin
            @(negedge clk_50M);
            if (noise && c < 2*D+1) begin
                start  = 1'($urandom_range(0, 1));
                mode   = 2'($urandom_range(0, 3));
                inj_en = 1'($urandom_range(0, 1));
            end else begin
                start = 1'b0;
            end
            if (c <= D) begin
                exp_ctrl = {1'b1, 1'b0, 1'b1, 1'b0, 5'(c-1)};
                mem_m[c-1]   = ref_wr(m, inj, c-1);
                wr_seen[c-1] = wrdata;
                n_checks++;
                if (wrdata !== mem_m[c-1]) begin
                    n_fail++;
                    $display("FAIL wrdata mode=%0d addr=%0d got=%h exp=%h", m, c-1, wrdata, mem_m[c-1]);
                end
            end else if (c <= 2*D) begin
                exp_ctrl = {1'b1, 1'b0, 1'b0, 1'b1, 5'(c-D-1)};
                if (c >= D+2) begin
                    rd_seen[c-D-2] = rddata;
                    n_checks++;
                    if (rddata !== mem_m[c-D-2]) begin
                        n_fail++;
                        $display("FAIL rddata mode=%0d addr=%0d got=%h exp=%h", m, c-D-2, rddata, mem_m[c-D-2]);
                    end
                end
            end else if (c == 2*D+1) begin
                exp_ctrl = 9'h100;
                rd_seen[D-1] = rddata;
                n_checks++;
                if (rddata !== mem_m[D-1]) begin
                    n_fail++;
                    $display("FAIL rddata_drain got=%h exp=%h", rddata, mem_m[D-1]);
                end
            end else begin
                exp_ctrl  = 9'h080;
                exp_err   = 0;
                exp_first = 0;
                for (int a = D-1; a >= 0; a--) begin
                    if (mem_m[a] != ref_pat(m, a)) begin
                        exp_err++;
                        exp_first = a;
                    end
                end
                n_checks++;
                if ({pass, err_cnt, first_err_addr} !== {exp_err == 0, 16'(exp_err), 5'(exp_first)}) begin
                    n_fail++;
                    $display("FAIL result mode=%0d inj=%0d got pass=%0d err=%0d first=%0d exp pass=%0d err=%0d first=%0d",
                             m, inj, pass, err_cnt, first_err_addr, exp_err == 0, exp_err, exp_first);
                end
            end
            n_checks++;
            if (ctrl !== exp_ctrl) begin
                n_fail++;
                $display("FAIL ctrl cycle=%0d got=%b exp=%b", c, ctrl, exp_ctrl);
            end
        end
    endtask

    task automatic test_reset;
        RST_N = 1'b0;
        repeat (3) @(negedge clk_50M);
        n_checks++;
        if (all_out !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%h exp=0", all_out);
        end
        n_checks++;
        if (s_all_out !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs_sat got=%h exp=0", s_all_out);
        end
        RST_N = 1'b1;
    endtask

    task automatic test_reset_mid_read;
        @(negedge clk_50M);
        mode = 2'd2; start = 1'b1;
        @(negedge clk_50M);
        start = 1'b0;
        repeat (D+4) @(negedge clk_50M);
        n_checks++;
        if (rden !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_read_reached rden got=%b exp=1", rden);
        end
        RST_N = 1'b0;
        #1;
        n_checks++;
        if (all_out !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_read got=%h exp=0", all_out);
        end
        @(negedge clk_50M);
        n_checks++;
        if (all_out !== '0) begin
            n_fail++;
            $display("FAIL reset_held got=%h exp=0", all_out);
        end
        RST_N = 1'b1;
        @(negedge clk_50M);
        n_checks++;
        if (all_out !== '0) begin
            n_fail++;
            $display("FAIL idle_after_reset got=%h exp=0", all_out);
        end
    endtask

    task automatic test_mode0;
        do_run(0, 1'b0, 1'b0);
        n_checks++;
        if (wr_seen[7] !== 8'h07) begin
            n_fail++;
            $display("FAIL mode0_addr7 got=%h exp=07", wr_seen[7]);
        end
    endtask

    task automatic test_modes;
        logic [7:0] exp9 [3];
        exp9[0] = 8'hF6; exp9[1] = 8'h02; exp9[2] = 8'hAA;
        for (int m = 1; m <= 3; m++) begin
            do_run(m, 1'b0, 1'b0);
            n_checks++;
            if (wr_seen[9] !== exp9[m-1]) begin
                n_fail++;
                $display("FAIL mode%0d_addr9 got=%h exp=%h", m, wr_seen[9], exp9[m-1]);
            end
        end
    endtask

    task automatic test_inject;
        do_run(0, 1'b1, 1'b0);
        n_checks++;
        if ({pass, err_cnt, first_err_addr, rd_seen[3]} !== {1'b0, 16'd1, 5'd3, 8'h02}) begin
            n_fail++;
            $display("FAIL inject got pass=%0d err=%0d first=%0d rd3=%h exp pass=0 err=1 first=3 rd3=02",
                     pass, err_cnt, first_err_addr, rd_seen[3]);
        end
    endtask

    task automatic test_start_ignored;
        do_run(1, 1'b0, 1'b1);
        do_run(3, 1'b1, 1'b1);
    endtask

    task automatic test_random;
        for (int i = 0; i < 3; i++) begin
            do_run(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
        end
    endtask

    task automatic test_saturate_cont;
        int bad [5];
        bad[0] = 6; bad[1] = 9; bad[2] = 13; bad[3] = 21; bad[4] = 30;
        @(negedge clk_50M);
        s_mode = 2'd0; s_start = 1'b1;
        for (int c = 1; c <= 4*D+4; c++) begin
            @(negedge clk_50M);
            s_start = 1'b0;
            if (c == D+1) begin
                for (int i = 0; i < 5; i++) begin
                    u_sat.mem[bad[i]] = ref_pat(0, bad[i]) ^ 8'($urandom_range(1, 255));
                end
            end
            if (c == 2*D+2) begin
                n_checks++;
                if ({s_done, s_busy, s_pass, s_err_cnt, s_first_err_addr} !== {1'b1, 1'b0, 1'b0, 2'd3, 5'd6}) begin
                    n_fail++;
                    $display("FAIL sat_done got done=%0d busy=%0d pass=%0d err=%0d first=%0d exp 1 0 0 3 6",
                             s_done, s_busy, s_pass, s_err_cnt, s_first_err_addr);
                end
            end
            if (c == 2*D+3) begin
                n_checks++;
                if ({s_busy, s_done, s_wren, s_rden, s_address, s_pass, s_err_cnt, s_first_err_addr}
                    !== {1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 2'd0, 5'd0}) begin
                    n_fail++;
                    $display("FAIL cont_restart got busy=%0d done=%0d wren=%0d rden=%0d addr=%0d pass=%0d err=%0d first=%0d",
                             s_busy, s_done, s_wren, s_rden, s_address, s_pass, s_err_cnt, s_first_err_addr);
                end
            end
            if (c == 4*D+4) begin
                n_checks++;
                if ({s_done, s_pass, s_err_cnt} !== {1'b1, 1'b1, 2'd0}) begin
                    n_fail++;
                    $display("FAIL cont_second_run got done=%0d pass=%0d err=%0d exp 1 1 0",
                             s_done, s_pass, s_err_cnt);
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_reset_mid_read();
        test_mode0();
        test_modes();
        test_inject();
        test_start_ignored();
        test_random();
        test_saturate_cont();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
